// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared state encoding, default width and output decode for the SPI transaction FSM
package spi_pkg;

    localparam int SPI_WIDTH = 8;

    typedef enum logic [2:0] {
        IDLE,
        GET_ADDR,
        ADDR_LATCH,
        READ_LOAD,
        READ_SHIFT,
        WRITE_SHIFT,
        WRITE_COMMIT,
        DONE
    } spi_state_t;

    typedef struct packed {
        logic sr_we;
        logic addr_we;
        logic dm_we;
        logic miso_buff_en;
        logic busy;
    } spi_out_t;

    // Moore decode; applied to the next state so the outputs come straight from flops
    function automatic spi_out_t spi_decode(input spi_state_t s);
        spi_out_t o;
        o.sr_we        = (s == READ_LOAD);
        o.addr_we      = (s == ADDR_LATCH);
        o.dm_we        = (s == WRITE_COMMIT);
        o.miso_buff_en = (s == READ_SHIFT);
        o.busy         = (s != IDLE);
        return o;
    endfunction

endpackage

// File: rtl/spi_txn_fsm_if.sv
// rtl/spi_txn_fsm_if.sv - conditioner-side inputs and datapath strobes of the SPI transaction FSM
interface spi_txn_fsm_if;

    logic cs_cond;
    logic sclk_pe;
    logic sclk_ne;
    logic rw_bit;
    logic sr_we;
    logic addr_we;
    logic dm_we;
    logic miso_buff_en;
    logic busy;

    modport master (
        output cs_cond, sclk_pe, sclk_ne, rw_bit,
        input  sr_we, addr_we, dm_we, miso_buff_en, busy
    );

    modport slave (
        input  cs_cond, sclk_pe, sclk_ne, rw_bit,
        output sr_we, addr_we, dm_we, miso_buff_en, busy
    );

endinterface

// File: rtl/spi_bitcounter.sv
// rtl/spi_bitcounter.sv - saturating bit counter shared by the address and data phases
module spi_bitcounter
    import spi_pkg::*;
#(
    parameter int WIDTH = SPI_WIDTH,
    parameter int CNTW  = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic last,
    output logic done
);

    localparam logic [CNTW-1:0] MAX = CNTW'(WIDTH);

    logic [CNTW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt <= '0;
        end else if (en && (cnt != MAX)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign done = (cnt == MAX);
    assign last = (cnt == MAX - 1'b1);

endmodule

// File: rtl/spi_txn_fsm.sv
// rtl/spi_txn_fsm.sv - SPI address+R/W byte then data byte sequencer; SPI_TIMEOUT_EN adds an SCLK stall abort
module spi_txn_fsm
    import spi_pkg::*;
#(
    parameter int WIDTH          = SPI_WIDTH,
    parameter int CNTW           = 4,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input logic          clk,
    input logic          reset,
    spi_txn_fsm_if.slave bus
);

    spi_state_t state, state_nxt;
    spi_out_t   outs;
    logic       cnt_clr, cnt_en, cnt_last, cnt_done;
    logic       shifting, abort, timeout;

    assign shifting = (state == GET_ADDR) || (state == READ_SHIFT) || (state == WRITE_SHIFT);

`ifdef SPI_TIMEOUT_EN
    localparam int TOW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TOW-1:0] to_cnt;

    // Any SCLK edge restarts the stall window; leaving the shift states clears it too
    always_ff @(posedge clk) begin
        if (reset || !shifting || bus.sclk_pe || bus.sclk_ne) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    assign timeout = shifting && !bus.sclk_pe && !bus.sclk_ne &&
                     (to_cnt == TOW'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = (TIMEOUT_CYCLES < 0);
`endif

    assign abort   = (state != IDLE) && (bus.cs_cond || timeout);
    assign cnt_clr = abort || !shifting;
    assign cnt_en  = !cnt_done &&
                     ((((state == GET_ADDR) || (state == WRITE_SHIFT)) && bus.sclk_pe) ||
                      ((state == READ_SHIFT) && bus.sclk_ne));

    spi_bitcounter #(.WIDTH(WIDTH), .CNTW(CNTW)) u_bitcounter (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .last  (cnt_last),
        .done  (cnt_done)
    );

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:         if (!bus.cs_cond) state_nxt = GET_ADDR;
                GET_ADDR:     if (cnt_en && cnt_last) state_nxt = ADDR_LATCH;
                ADDR_LATCH:   state_nxt = bus.rw_bit ? READ_LOAD : WRITE_SHIFT;
                READ_LOAD:    state_nxt = READ_SHIFT;
                READ_SHIFT:   if (cnt_en && cnt_last) state_nxt = DONE;
                WRITE_SHIFT:  if (cnt_en && cnt_last) state_nxt = WRITE_COMMIT;
                WRITE_COMMIT: state_nxt = DONE;
                DONE:         state_nxt = DONE;
                default:      state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            outs  <= '0;
        end else begin
            state <= state_nxt;
            outs  <= spi_decode(state_nxt);
        end
    end

    assign bus.sr_we        = outs.sr_we;
    assign bus.addr_we      = outs.addr_we;
    assign bus.dm_we        = outs.dm_we;
    assign bus.miso_buff_en = outs.miso_buff_en;
    assign bus.busy         = outs.busy;

endmodule

// File: tb/tb_spi_txn_fsm.sv
// tb/tb_spi_txn_fsm.sv - directed bench with a timestamp-based transaction model checked every cycle
module tb_spi_txn_fsm;

    localparam int TO = 16;

    logic clk = 1'b0;
    logic reset;

    spi_txn_fsm_if bus ();

    spi_txn_fsm #(.WIDTH(8), .CNTW(4), .TIMEOUT_CYCLES(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit armed  = 1'b0;

    // Model: session flag, edge tallies and the posedge numbers at which each byte completed
    int n = 0;
    bit m_act = 1'b0;
    bit m_rd;
    int m_ape, m_dcnt, m_quiet, t_addr, t_data;
    bit e_busy, e_addr, e_sr, e_dm, e_miso;

    int cnt_addr, cnt_sr, cnt_dm;

    task automatic cmp(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (armed) begin
            cmp("busy", bus.busy, e_busy);
            cmp("addr_we", bus.addr_we, e_addr);
            cmp("sr_we", bus.sr_we, e_sr);
            cmp("dm_we", bus.dm_we, e_dm);
            cmp("miso_buff_en", bus.miso_buff_en, e_miso);
            cnt_addr += bus.addr_we;
            cnt_sr   += bus.sr_we;
            cnt_dm   += bus.dm_we;
        end
    end

    // Drive one cycle of inputs, advance the model, and return just after the posedge
    task automatic step(input bit rst, input bit cs, input bit pe, input bit ne, input bit rw);
        bit waiting;
        @(negedge clk);
        #1;
        reset = rst; bus.cs_cond = cs; bus.sclk_pe = pe; bus.sclk_ne = ne; bus.rw_bit = rw;
        n++;
        waiting = m_act && !cs && ((m_ape < 8) ||
                  (m_dcnt < 8 && ((!m_rd && n >= t_addr + 2) || (m_rd && n >= t_addr + 3))));
        m_quiet = (waiting && !pe && !ne) ? m_quiet + 1 : 0;
        if (rst) begin
            m_act = 1'b0;
        end else if (!m_act) begin
            if (!cs) begin
                m_act = 1'b1; m_rd = 1'b0; m_ape = 0; m_dcnt = 0; m_quiet = 0;
                t_addr = -100; t_data = -100;
            end
        end else if (cs) begin
            m_act = 1'b0;
`ifdef SPI_TIMEOUT_EN
        end else if (m_quiet == TO) begin
            m_act = 1'b0;
`endif
        end else if (m_ape < 8) begin
            if (pe) begin
                m_ape++;
                if (m_ape == 8) t_addr = n;
            end
        end else begin
            if (n == t_addr + 1) m_rd = rw;
            if (m_dcnt < 8 && ((!m_rd && n >= t_addr + 2 && pe) || (m_rd && n >= t_addr + 3 && ne))) begin
                m_dcnt++;
                if (m_dcnt == 8) t_data = n;
            end
        end
        e_busy = m_act;
        e_addr = m_act && (n == t_addr);
        e_sr   = m_act && m_rd && (n == t_addr + 1);
        e_miso = m_act && m_rd && (n >= t_addr + 2) && (m_dcnt < 8);
        e_dm   = m_act && !m_rd && (m_dcnt == 8) && (n == t_data);
        @(posedge clk);
        #1;
        armed = 1'b1;
    endtask

    task automatic edges(input int k, input bit pe, input bit ne, input bit rw);
        for (int i = 0; i < k; i++) begin
            step(0, 0, pe, ne, rw);
            step(0, 0, 0, 0, rw);
        end
    endtask

    task automatic clear_counts();
        @(negedge clk);
        #2;
        cnt_addr = 0; cnt_sr = 0; cnt_dm = 0;
    endtask

    initial begin
        reset = 1'b1; bus.cs_cond = 1'b1; bus.sclk_pe = 1'b0; bus.sclk_ne = 1'b0; bus.rw_bit = 1'b0;
        cnt_addr = 0; cnt_sr = 0; cnt_dm = 0;

        step(1, 1, 0, 0, 0);
        step(1, 0, 1, 1, 1);
        cmp("reset_busy", bus.busy, 0);
        cmp("reset_miso", bus.miso_buff_en, 0);
        step(0, 1, 0, 0, 0);

        // Write: addr_we one cycle after the 8th pe, dm_we one cycle after the 16th
        clear_counts();
        step(0, 0, 0, 0, 0);
        cmp("wr_busy_enter", bus.busy, 1);
        edges(7, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        cmp("wr_addr_we_lat", bus.addr_we, 1);
        step(0, 0, 0, 0, 0);
        cmp("wr_addr_we_once", bus.addr_we, 0);
        edges(7, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        cmp("wr_dm_we_lat", bus.dm_we, 1);
        step(0, 0, 1, 1, 0);
        cmp("wr_done_busy", bus.busy, 1);
        step(0, 1, 0, 0, 0);
        cmp("wr_idle_busy", bus.busy, 0);
        cmp("wr_dm_count", cnt_dm, 1);
        cmp("wr_sr_count", cnt_sr, 0);

        // Read: addr_we, sr_we, then miso until the 8th ne
        clear_counts();
        step(0, 0, 0, 0, 1);
        edges(7, 1, 1, 1);
        step(0, 0, 1, 0, 1);
        cmp("rd_addr_we", bus.addr_we, 1);
        step(0, 0, 0, 0, 1);
        cmp("rd_sr_we", bus.sr_we, 1);
        step(0, 0, 0, 0, 1);
        cmp("rd_miso_on", bus.miso_buff_en, 1);
        edges(7, 0, 1, 1);
        step(0, 0, 1, 1, 1);
        cmp("rd_miso_off", bus.miso_buff_en, 0);
        cmp("rd_done_busy", bus.busy, 1);
        step(0, 1, 0, 0, 0);
        cmp("rd_dm_count", cnt_dm, 0);

        // Abort after 3 data pe, with a same-cycle pe that must lose
        clear_counts();
        step(0, 0, 0, 0, 0);
        edges(8, 1, 0, 0);
        edges(3, 1, 0, 0);
        step(0, 1, 1, 0, 0);
        cmp("abort_busy", bus.busy, 0);
        step(0, 1, 0, 0, 0);
        cmp("abort_dm_count", cnt_dm, 0);

        // Reset in READ_SHIFT, then cs still low re-enters the address phase
        step(0, 0, 0, 0, 1);
        edges(8, 1, 0, 1);
        step(0, 0, 0, 0, 1);
        edges(3, 0, 1, 1);
        cmp("rst_mid_miso_pre", bus.miso_buff_en, 1);
        step(1, 0, 0, 0, 1);
        cmp("rst_mid_miso", bus.miso_buff_en, 0);
        cmp("rst_mid_busy", bus.busy, 0);
        step(0, 0, 0, 0, 0);
        cmp("rst_reenter_busy", bus.busy, 1);
        edges(8, 1, 0, 0);
        step(0, 1, 0, 0, 0);

        // 12 data pe, edges in DONE, then a second transaction
        clear_counts();
        step(0, 0, 0, 0, 0);
        edges(8, 1, 0, 0);
        edges(12, 1, 1, 0);
        edges(4, 1, 0, 0);
        cmp("extra_dm_count", cnt_dm, 1);
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        edges(16, 1, 0, 0);
        cmp("second_dm_count", cnt_dm, 2);
        step(0, 1, 0, 0, 0);

        // SCLK stall in the address phase
        step(0, 0, 0, 0, 0);
        edges(3, 1, 0, 0);
        for (int i = 0; i < TO + 4; i++) step(0, 0, 0, 0, 0);
`ifdef SPI_TIMEOUT_EN
        cmp("stall_busy", bus.busy, 0);
`else
        cmp("stall_busy", bus.busy, 1);
`endif
        edges(5, 1, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);

        @(negedge clk);
        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
